// File: rtl/inst_mem_ctrl.sv
// inst_mem_ctrl: instruction memory with a byte-serial image loader.
//
// A loader streams bytes in while the core is held in reset. Each group of
// four bytes is packed big-endian into one word and written to the next free
// location. A load that ends mid-group commits the partial word with its
// missing low bytes zeroed. The core fetches combinationally while idle.
//
// Ports:
//   i_clk        clock, all state on the rising edge
//   i_rst        asynchronous active-high reset
//   i_inst_ren   core fetch enable
//   i_inst_addr  core fetch byte address (N_INST_ADDR bits)
//   o_inst_data  fetched instruction (N_INST_DATA bits), 0 when gated
//   i_ld_start   pulse: begin an image load (honoured only when idle)
//   i_ld_valid   loader byte valid
//   i_ld_byte    loader byte
//   i_ld_end     pulse: end the image load (honoured only while loading)
//   o_ld_ready   loader bytes are accepted
//   o_ld_done    one-cycle pulse when a load completes
//   o_ld_err     sticky overflow flag for the current/last load
//   o_ld_words   words written by the last load (DEPTH_LOG2+1 bits)
//   o_cpu_hold   holds the core in reset while a load is in progress
module inst_mem_ctrl #(
    parameter int DEPTH_LOG2  = 10,
    parameter int N_INST_ADDR = 32,
    parameter int N_INST_DATA = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_inst_ren,
    input  logic [N_INST_ADDR-1:0] i_inst_addr,
    output logic [N_INST_DATA-1:0] o_inst_data,
    input  logic                   i_ld_start,
    input  logic                   i_ld_valid,
    input  logic [7:0]             i_ld_byte,
    input  logic                   i_ld_end,
    output logic                   o_ld_ready,
    output logic                   o_ld_done,
    output logic                   o_ld_err,
    output logic [DEPTH_LOG2:0]    o_ld_words,
    output logic                   o_cpu_hold
);

    localparam int unsigned       DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT
    } state_t;

    state_t                  state, state_nxt;
    logic [1:0]              cnt, cnt_nxt;
    logic [DEPTH_LOG2:0]     ptr, ptr_nxt;
    logic [DEPTH_LOG2:0]     words, words_nxt;
    logic [23:0]             pbuf, pbuf_nxt;
    logic                    err, err_nxt;
    logic                    done, done_nxt;

    logic                    flush;
    logic                    finish;
    logic                    we;
    logic [DEPTH_LOG2-1:0]   waddr;
    logic [31:0]             wdata;

    logic [N_INST_DATA-1:0]  mem [DEPTH];

    logic [DEPTH_LOG2-1:0]   rd_idx;
    logic                    rd_oob;
    logic                    unused_addr_lsb;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            cnt   <= '0;
            ptr   <= '0;
            words <= '0;
            pbuf  <= '0;
            err   <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ptr   <= ptr_nxt;
            words <= words_nxt;
            pbuf  <= pbuf_nxt;
            err   <= err_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        words_nxt = words;
        pbuf_nxt  = pbuf;
        err_nxt   = err;
        done_nxt  = 1'b0;
        flush     = 1'b0;
        finish    = 1'b0;
        we        = 1'b0;
        waddr     = ptr[DEPTH_LOG2-1:0];
        // The partial buffer is cleared after every flushed word, so bytes
        // not yet received are already zero when a short word is committed.
        wdata     = {pbuf, 8'h00};

        case (state)
            IDLE: begin
                if (i_ld_start) begin
                    state_nxt = LOAD;
                    cnt_nxt   = '0;
                    ptr_nxt   = '0;
                    words_nxt = '0;
                    err_nxt   = 1'b0;
                    pbuf_nxt  = '0;
                end
            end
            LOAD: begin
                if (i_ld_valid) begin
                    case (cnt)
                        2'd0: pbuf_nxt[23:16] = i_ld_byte;
                        2'd1: pbuf_nxt[15:8]  = i_ld_byte;
                        2'd2: pbuf_nxt[7:0]   = i_ld_byte;
                        default: begin
                            flush    = 1'b1;
                            wdata    = {pbuf, i_ld_byte};
                            pbuf_nxt = '0;
                        end
                    endcase
                    cnt_nxt = cnt + 2'd1;
                end
                // End is judged on the counter after any byte taken this cycle.
                if (i_ld_end) begin
                    if (cnt_nxt == 2'd0) begin
                        state_nxt = IDLE;
                        finish    = 1'b1;
                    end else begin
                        state_nxt = COMMIT;
                    end
                end
            end
            COMMIT: begin
                flush     = 1'b1;
                pbuf_nxt  = '0;
                cnt_nxt   = '0;
                state_nxt = IDLE;
                finish    = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase

        if (flush) begin
            if (ptr == FULL) begin
                err_nxt = 1'b1;
            end else begin
                we      = 1'b1;
                ptr_nxt = ptr + 1'b1;
            end
        end

        if (finish) begin
            words_nxt = ptr_nxt;
            done_nxt  = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (we) begin
            mem[waddr] <= N_INST_DATA'(wdata);
        end
    end

    assign rd_idx          = i_inst_addr[DEPTH_LOG2+1:2];
    assign rd_oob          = (i_inst_addr >> (DEPTH_LOG2 + 2)) != '0;
    assign unused_addr_lsb = ^i_inst_addr[1:0];

    always_comb begin
        o_inst_data = '0;
        if (i_inst_ren && !o_cpu_hold && !rd_oob) begin
            o_inst_data = mem[rd_idx];
        end
    end

    assign o_ld_ready = (state == LOAD);
    assign o_cpu_hold = (state != IDLE);
    assign o_ld_done  = done;
    assign o_ld_err   = err;
    assign o_ld_words = words;

endmodule

// File: tb/tb_inst_mem_ctrl.sv
module tb_inst_mem_ctrl;

    typedef struct {
        int words_a;
        int err_a;
        int words_b;
        int err_b;
    } ld_exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
    } rd_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_ren;
    logic [31:0] inst_addr;
    logic        ld_start, ld_valid, ld_end;
    logic [7:0]  ld_byte;

    logic [31:0] data_a, data_b;
    logic        ready_a, ready_b, done_a, done_b, err_a, err_b, hold_a, hold_b;
    logic [10:0] words_a;
    logic [2:0]  words_b;

    int errors = 0;
    int checks = 0;

    ld_exp_t     ld_q [$];
    rd_exp_t     rd_q [$];
    logic [31:0] mdl_a [int];
    logic [31:0] mdl_b [int];

    always #5 clk = ~clk;

    inst_mem_ctrl #(.DEPTH_LOG2(10), .N_INST_ADDR(32), .N_INST_DATA(32)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_inst_ren(inst_ren), .i_inst_addr(inst_addr),
        .o_inst_data(data_a), .i_ld_start(ld_start), .i_ld_valid(ld_valid),
        .i_ld_byte(ld_byte), .i_ld_end(ld_end), .o_ld_ready(ready_a),
        .o_ld_done(done_a), .o_ld_err(err_a), .o_ld_words(words_a),
        .o_cpu_hold(hold_a)
    );

    inst_mem_ctrl #(.DEPTH_LOG2(2), .N_INST_ADDR(32), .N_INST_DATA(32)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_inst_ren(inst_ren), .i_inst_addr(inst_addr),
        .o_inst_data(data_b), .i_ld_start(ld_start), .i_ld_valid(ld_valid),
        .i_ld_byte(ld_byte), .i_ld_end(ld_end), .o_ld_ready(ready_b),
        .o_ld_done(done_b), .o_ld_err(err_b), .o_ld_words(words_b),
        .o_cpu_hold(hold_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
    endtask

    task automatic end_load();
        ld_end = 1'b1;
        tick();
        ld_end = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] b[$]);
        foreach (b[i]) begin
            ld_valid = 1'b1;
            ld_byte  = b[i];
            tick();
        end
        ld_valid = 1'b0;
    endtask

    // Reference packing: big-endian groups of four, partial word zero-filled
    // only when it is committed; writes beyond the depth are dropped.
    task automatic model_load(input logic [7:0] b[$], input bit commit_partial,
                              output ld_exp_t e);
        int n_full, n_words;
        logic [31:0] w;
        n_full  = b.size() / 4;
        n_words = n_full;
        for (int g = 0; g < n_full; g++) begin
            w = {b[4*g], b[4*g+1], b[4*g+2], b[4*g+3]};
            if (g < 1024) mdl_a[g] = w;
            if (g < 4)    mdl_b[g] = w;
        end
        if (commit_partial && (b.size() % 4 != 0)) begin
            w = '0;
            for (int k = 0; k < b.size() % 4; k++) w[31-8*k -: 8] = b[4*n_full+k];
            if (n_full < 1024) mdl_a[n_full] = w;
            if (n_full < 4)    mdl_b[n_full] = w;
            n_words++;
        end
        e.words_a = (n_words > 1024) ? 1024 : n_words;
        e.err_a   = (n_words > 1024) ? 1 : 0;
        e.words_b = (n_words > 4) ? 4 : n_words;
        e.err_b   = (n_words > 4) ? 1 : 0;
    endtask

    function automatic logic [31:0] look(bit is_b, logic [31:0] addr);
        int dl = is_b ? 2 : 10;
        int idx;
        if ((addr >> (dl + 2)) != 0) return '0;
        idx = int'((addr >> 2) & ((32'd1 << dl) - 1));
        if (is_b) return mdl_b.exists(idx) ? mdl_b[idx] : 32'h0;
        return mdl_a.exists(idx) ? mdl_a[idx] : 32'h0;
    endfunction

    task automatic fetch(input string nm, input logic [31:0] addr, input logic ren,
                         input bit held);
        rd_exp_t e, got;
        e.a = (ren && !held) ? look(1'b0, addr) : 32'h0;
        e.b = (ren && !held) ? look(1'b1, addr) : 32'h0;
        rd_q.push_back(e);
        inst_ren  = ren;
        inst_addr = addr;
        #1;
        got = rd_q.pop_front();
        checks++;
        if (data_a !== got.a) begin
            errors++;
            $display("FAIL %s dut_a: got %h want %h", nm, data_a, got.a);
        end
        checks++;
        if (data_b !== got.b) begin
            errors++;
            $display("FAIL %s dut_b: got %h want %h", nm, data_b, got.b);
        end
        inst_ren = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        ld_exp_t e;
        for (int c = 0; c < 6; c++) begin
            if (done_a === 1'b1) begin
                e = ld_q.pop_front();
                checks++;
                if (words_a !== 11'(e.words_a) || err_a !== 1'(e.err_a)) begin
                    errors++;
                    $display("FAIL %s dut_a words/err: got %0d/%b want %0d/%0d",
                             nm, words_a, err_a, e.words_a, e.err_a);
                end
                checks++;
                if (done_b !== 1'b1 || words_b !== 3'(e.words_b) || err_b !== 1'(e.err_b)) begin
                    errors++;
                    $display("FAIL %s dut_b done/words/err: got %b/%0d/%b want 1/%0d/%0d",
                             nm, done_b, words_b, err_b, e.words_b, e.err_b);
                end
                tick();
                checks++;
                if (done_a !== 1'b0 || hold_a !== 1'b0) begin
                    errors++;
                    $display("FAIL %s done_one_cycle: got done=%b hold=%b want 0/0",
                             nm, done_a, hold_a);
                end
                return;
            end
            tick();
        end
        checks++;
        errors++;
        $display("FAIL %s done_timeout: got no done want done within 6 cycles", nm);
        void'(ld_q.pop_front());
    endtask

    task automatic test_reset();
        rst = 1'b1; inst_ren = 1'b0; inst_addr = '0;
        ld_start = 1'b0; ld_valid = 1'b0; ld_end = 1'b0; ld_byte = '0;
        #1;
        checks++;
        if ({hold_a, ready_a, done_a, err_a} !== 4'b0000 || words_a !== 11'd0) begin
            errors++;
            $display("FAIL reset_state: got hold/ready/done/err=%b%b%b%b words=%0d want 0000 0",
                     hold_a, ready_a, done_a, err_a, words_a);
        end
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] b[$] = '{8'h34, 8'h08, 8'h00, 8'h01, 8'h34, 8'h09, 8'h00, 8'h02};
        ld_exp_t e;
        start_load();
        checks++;
        if (ready_a !== 1'b1 || hold_a !== 1'b1) begin
            errors++;
            $display("FAIL load_entry: got ready=%b hold=%b want 1/1", ready_a, hold_a);
        end
        send_bytes(b);
        model_load(b, 1'b1, e);
        ld_q.push_back(e);
        end_load();
        wait_done("basic");
        fetch("basic_addr0", 32'h0, 1'b1, 1'b0);
        fetch("basic_addr4", 32'h4, 1'b1, 1'b0);
    endtask

    task automatic test_commit();
        logic [7:0] b[$] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        ld_exp_t e;
        start_load();
        send_bytes(b);
        // A start pulse mid-load must not restart the load.
        start_load();
        model_load(b, 1'b1, e);
        ld_q.push_back(e);
        end_load();
        checks++;
        if (hold_a !== 1'b1 || ready_a !== 1'b0 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL commit_state: got hold=%b ready=%b done=%b want 1/0/0",
                     hold_a, ready_a, done_a);
        end
        wait_done("commit");
        fetch("commit_addr0", 32'h0, 1'b1, 1'b0);
        fetch("commit_addr4", 32'h4, 1'b1, 1'b0);
    endtask

    task automatic test_valid_end();
        logic [7:0] b[$] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [7:0] head[$] = '{8'h11, 8'h22, 8'h33};
        ld_exp_t e;
        start_load();
        send_bytes(head);
        model_load(b, 1'b1, e);
        ld_q.push_back(e);
        ld_valid = 1'b1; ld_byte = 8'h44; ld_end = 1'b1;
        tick();
        ld_valid = 1'b0; ld_end = 1'b0;
        checks++;
        if (done_a !== 1'b1 || hold_a !== 1'b0) begin
            errors++;
            $display("FAIL valid_end_no_commit: got done=%b hold=%b want 1/0", done_a, hold_a);
        end
        wait_done("valid_end");
        fetch("valid_end_addr0", 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_overflow();
        logic [7:0] b[$];
        ld_exp_t e;
        for (int i = 0; i < 20; i++) b.push_back(8'(8'h40 + i));
        start_load();
        send_bytes(b);
        checks++;
        if (ready_b !== 1'b1 || err_b !== 1'b1 || err_a !== 1'b0) begin
            errors++;
            $display("FAIL overflow_flags: got ready_b=%b err_b=%b err_a=%b want 1/1/0",
                     ready_b, err_b, err_a);
        end
        model_load(b, 1'b1, e);
        ld_q.push_back(e);
        end_load();
        wait_done("overflow");
        for (int w = 0; w < 5; w++) fetch($sformatf("overflow_word%0d", w), 32'(4 * w), 1'b1, 1'b0);
    endtask

    task automatic test_fetch_gating();
        logic [7:0] none[$];
        ld_exp_t e;
        start_load();
        checks++;
        if (hold_a !== 1'b1 || err_b !== 1'b0) begin
            errors++;
            $display("FAIL gating_hold: got hold=%b err_b=%b want 1/0", hold_a, err_b);
        end
        fetch("gating_during_load", 32'h0, 1'b1, 1'b1);
        model_load(none, 1'b1, e);
        ld_q.push_back(e);
        end_load();
        wait_done("empty_load");
        fetch("gating_ren0", 32'h0, 1'b0, 1'b0);
        fetch("gating_oob", 32'h1000, 1'b1, 1'b0);
        fetch("gating_lsb_ignored", 32'h7, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic [7:0] b[$] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        ld_exp_t e;
        start_load();
        send_bytes(b);
        model_load(b, 1'b0, e);
        rst = 1'b1;
        #1;
        checks++;
        if (hold_a !== 1'b0 || ready_a !== 1'b0 || words_a !== 11'd0 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got hold=%b ready=%b words=%0d done=%b want 0/0/0/0",
                     hold_a, ready_a, words_a, done_a);
        end
        #2;
        rst = 1'b0;
        tick();
        fetch("reset_kept_word0", 32'h0, 1'b1, 1'b0);
        fetch("reset_partial_dropped", 32'h4, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] b[$] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hC0};
        ld_exp_t e;
        start_load();
        send_bytes(b);
        model_load(b, 1'b1, e);
        ld_q.push_back(e);
        end_load();
        wait_done("back_to_back");
        fetch("b2b_addr0", 32'h0, 1'b1, 1'b0);
        fetch("b2b_addr4", 32'h4, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_commit();
        test_valid_end();
        test_overflow();
        test_fetch_gating();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish before 200000");
        $fatal(1);
    end

endmodule
